// File: rtl/exec_fsm.sv
// Decode/execute control FSM sitting behind the instruction-fetch FSM.
// Latency: NOP/JMP/BZ retire 3 cycles after ir_valid, ALU 6, STORE 6 + MFC wait, LOAD 7 + MFC wait.
// Backpressure: memory states wait on MFC and fault to HALT after MFC_TIMEOUT idle cycles.
module exec_fsm #(
  parameter int RAW         = 3,
  parameter int MFC_TIMEOUT = 15,
  parameter int CW          = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ir_valid,
  input  logic [3:0]     opcode,
  input  logic [RAW-1:0] rd,
  input  logic [RAW-1:0] rs,
  input  logic           zero,
  input  logic           MFC,
  output logic           rf_out,
  output logic [RAW-1:0] rf_sel,
  output logic           rf_we,
  output logic           alu_a_en,
  output logic           alu_res_en,
  output logic           alu_res_out,
  output logic [2:0]     alu_op,
  output logic           mar_en,
  output logic           mdr_en_read,
  output logic           mdr_en_write,
  output logic           mdr_out,
  output logic           mem_en,
  output logic           mem_rw,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           done,
  output logic           busy,
  output logic           halted,
  output logic           illegal,
  output logic           bus_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_ALU_A, S_ALU_B, S_WB, S_MEM_ADDR, S_RD_WAIT, S_RD_CAP,
    S_RD_WB, S_WR_DATA, S_WR_WAIT, S_FAULT, S_JMP, S_PC_INC, S_DONE, S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_limit;
  logic          w_is_ill;
  logic          w_wait_stay;
  logic [2:0]    w_alu_op;

  assign w_limit     = (r_cnt == CW'(MFC_TIMEOUT));
  assign w_is_ill    = (opcode >= 4'hA) && (opcode <= 4'hE);
  // Counter only runs while we remain in the same wait state; any entry clears it.
  assign w_wait_stay = (w_next == r_state) && ((r_state == S_RD_WAIT) || (r_state == S_WR_WAIT));
  assign w_alu_op    = 3'(opcode - 4'd1);

  // Next-state decode; opcode is held stable by fetch until done.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (ir_valid) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: w_next = S_ALU_A;
          4'h6, 4'h7:                   w_next = S_MEM_ADDR;
          4'h8:                         w_next = S_JMP;
          4'h9:                         w_next = zero ? S_JMP : S_PC_INC;
          4'hF:                         w_next = S_HALT;
          default:                      w_next = S_PC_INC; // NOP and undefined opcodes
        endcase
      end
      S_ALU_A:    w_next = S_ALU_B;
      S_ALU_B:    w_next = S_WB;
      S_WB:       w_next = S_PC_INC;
      S_MEM_ADDR: w_next = (opcode == 4'h6) ? S_RD_WAIT : S_WR_DATA;
      // MFC arriving on the limit cycle still counts as a normal completion.
      S_RD_WAIT:  w_next = MFC ? S_RD_CAP : (w_limit ? S_FAULT : S_RD_WAIT);
      S_RD_CAP:   w_next = S_RD_WB;
      S_RD_WB:    w_next = S_PC_INC;
      S_WR_DATA:  w_next = S_WR_WAIT;
      S_WR_WAIT:  w_next = MFC ? S_PC_INC : (w_limit ? S_FAULT : S_WR_WAIT);
      S_FAULT:    w_next = S_HALT;
      S_JMP:      w_next = S_DONE;
      S_PC_INC:   w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_IDLE;
    endcase
  end

  // State, wait counter and outputs; outputs are decoded from the next state so they
  // line up with the state register while coming straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      rf_out       <= 1'b0;
      rf_sel       <= '0;
      rf_we        <= 1'b0;
      alu_a_en     <= 1'b0;
      alu_res_en   <= 1'b0;
      alu_res_out  <= 1'b0;
      alu_op       <= 3'd0;
      mar_en       <= 1'b0;
      mdr_en_read  <= 1'b0;
      mdr_en_write <= 1'b0;
      mdr_out      <= 1'b0;
      mem_en       <= 1'b0;
      mem_rw       <= 1'b0;
      pc_inc       <= 1'b0;
      pc_load      <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_wait_stay ? r_cnt + CW'(1) : '0;
      rf_out       <= 1'b0;
      rf_sel       <= '0;
      rf_we        <= 1'b0;
      alu_a_en     <= 1'b0;
      alu_res_en   <= 1'b0;
      alu_res_out  <= 1'b0;
      alu_op       <= 3'd0;
      mar_en       <= 1'b0;
      mdr_en_read  <= 1'b0;
      mdr_en_write <= 1'b0;
      mdr_out      <= 1'b0;
      mem_en       <= 1'b0;
      mem_rw       <= 1'b0;
      pc_inc       <= 1'b0;
      pc_load      <= 1'b0;
      done         <= 1'b0;
      busy         <= (w_next != S_IDLE) && (w_next != S_HALT);
      halted       <= (w_next == S_HALT);
      illegal      <= illegal | ((r_state == S_DECODE) && w_is_ill);
      bus_err      <= bus_err | (w_next == S_FAULT);
      case (w_next)
        S_ALU_A:    begin rf_out <= 1'b1; rf_sel <= rs; alu_a_en <= 1'b1;  alu_op <= w_alu_op; end
        S_ALU_B:    begin rf_out <= 1'b1; rf_sel <= rd; alu_res_en <= 1'b1; alu_op <= w_alu_op; end
        S_WB:       begin alu_res_out <= 1'b1; rf_we <= 1'b1; alu_op <= w_alu_op; end
        S_MEM_ADDR: begin rf_out <= 1'b1; rf_sel <= rs; mar_en <= 1'b1; end
        S_RD_WAIT:  begin mem_en <= 1'b1; mem_rw <= 1'b1; end
        S_RD_CAP:   begin mem_en <= 1'b1; mem_rw <= 1'b1; mdr_en_read <= 1'b1; end
        S_RD_WB:    begin mdr_out <= 1'b1; rf_we <= 1'b1; end
        S_WR_DATA:  begin rf_out <= 1'b1; rf_sel <= rd; mdr_en_write <= 1'b1; end
        S_WR_WAIT:  begin mem_en <= 1'b1; mem_rw <= 1'b0; end
        S_JMP:      begin rf_out <= 1'b1; rf_sel <= rs; pc_load <= 1'b1; end
        S_PC_INC:   pc_inc <= 1'b1;
        S_DONE:     done <= 1'b1;
        default:    ;
      endcase
    end
  end

endmodule
